shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
- Multicycle shift sequencer for the processor's shift path.
- Holds a working register and applies a single 1-bit shift stage per cycle until the requested shift amount is consumed. The stage is SLL, or SRL/SRA selected by op.
- Offers a start/busy/done handshake to the execute stage, so shifts can share a minimal shifter instead of a full 32-bit barrel shifter.
- Supports SLL, SRL and SRA on 32-bit data.

Parameters:
- WIDTH, 32, data width in bits.
- SHAMT_W, 5, shift-amount width; must satisfy 2^SHAMT_W == WIDTH.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; accepted only when busy==0.
- op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 reserved (executed as SLL).
- data_in  in  WIDTH  operand, sampled on the accepting edge.
- shamt  in  SHAMT_W  shift amount, sampled on the accepting edge.
- result  out  WIDTH  final shifted value; registered.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle completion pulse; result is valid while done is high.

Behaviour:
- Reset values: state=IDLE, result=0, busy=0, done=0, work=0, count=0, op_r=0.
- Reset applies on any edge with reset=1 and overrides start, including mid-SHIFT. The operation in flight is dropped and no done pulse is produced.
- FSM has three states: IDLE, SHIFT, DONE.
- Accept condition: start=1 and state in {IDLE, DONE}, so back-to-back requests are allowed from DONE.
- On accept:
  - work<=data_in, op_r<=op, count<=shamt.
  - If shamt==0: result<=data_in and next state DONE.
  - Otherwise next state SHIFT.
- start while busy (SHIFT) is ignored. Inputs are not re-sampled.
- SHIFT, each edge:
  - work shifts by one position. SLL fills bit0 with 0. SRL fills the MSB with 0. SRA replicates the MSB.
  - count decrements by 1.
  - When count==1 on that edge: result<=shifted value, next state DONE.
- DONE lasts exactly one cycle with done=1, then IDLE unless a new start is accepted.
- busy=1 iff state==SHIFT. done=1 iff state==DONE. Both are registered (state decode only).
- result holds its value until the next operation completes. Intermediate shifts are never visible on result.
- Latency, with capture at edge E0 and n=shamt:
  - done is high in the cycle after edge E_n.
  - n=0: done follows E0 directly.
  - n=31: 31 SHIFT edges.
- Shift amounts at or above WIDTH cannot be expressed, because shamt is SHAMT_W bits wide.
- No wrap-around of count: the decrement stops at exit from SHIFT.

Optional Feature:
- Macro: SHIFT_SEQ_FAST4_EN.
- Defined:
  - In SHIFT, when count>=4, work shifts by 4 (same fill rules) and count decreases by 4.
  - Otherwise work shifts by 1 and count decreases by 1.
  - The exit rule becomes: the step that makes count reach 0 also loads result and moves to DONE.
  - Latency is floor(n/4)+(n mod 4) edges after E0 (n=31 gives 10). Results are identical to the non-FAST build.
- Undefined: 1-bit steps only, as described under Behaviour.

Test Plan:
- SLL, data_in=0x00000001, shamt=4 -> busy high for 4 cycles; done after E4; result=0x00000010.
- SRA, data_in=0x80000000, shamt=31 -> result=0xFFFFFFFF, done after E31. The same inputs with SRL -> result=0x00000001.
- shamt=0, op=SRA, data_in=0xDEADBEEF -> no SHIFT state entered; done after E0; result=0xDEADBEEF.
- start re-asserted with data_in=0x12345678 during SHIFT of SLL 0x0000000F by 8 -> second request ignored; result=0x00000F00. Then a start issued during the DONE cycle is accepted, and its result follows normally.
- reset asserted at E3 of SRL 0xF0000000 by 16 -> next cycle state IDLE, result=0, busy=0, done never pulses. A following SRL 0xF0000000 by 16 -> result=0x0000F000.
- With SHIFT_SEQ_FAST4_EN, SLL 0x00000003 by 7 -> done after E4 (one 4-step plus three 1-steps); result=0x00000180.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl
//
// Multicycle shift sequencer for the processor's shift path. A working
// register is shifted by one bit position per clock (SLL, SRL or SRA) until
// the requested amount is consumed, so the execute stage can share a tiny
// shifter instead of a full barrel shifter.
//
// Optional feature (macro SHIFT_SEQ_FAST4_EN): while at least four positions
// remain, each step shifts by four. Results are identical to the 1-bit build;
// only the latency changes (floor(n/4) + n mod 4 steps).
//
// Ports:
//   clock    in   1        system clock, rising edge
//   reset    in   1        synchronous active-high reset
//   start    in   1        request pulse, accepted in IDLE or DONE
//   op       in   2        00 SLL, 01 SRL, 10 SRA, 11 reserved (acts as SLL)
//   data_in  in   WIDTH    operand, sampled on the accepting edge
//   shamt    in   SHAMT_W  shift amount, sampled on the accepting edge
//   result   out  WIDTH    final shifted value, registered, held until the
//                          next operation completes
//   busy     out  1        high while shifting
//   done     out  1        one-cycle completion pulse
// ---------------------------------------------------------------------------
module shift_seq_ctrl #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   result,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0]         OP_SRL  = 2'b01;
    localparam logic [1:0]         OP_SRA  = 2'b10;
    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);
`ifdef SHIFT_SEQ_FAST4_EN
    localparam logic [SHAMT_W-1:0] CNT_FOUR = SHAMT_W'(4);
`endif

    state_t             state;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] count;
    logic [1:0]         op_r;

    // Next working value and remaining count for one SHIFT-state step.
    logic [WIDTH-1:0]   shifted;
    logic [SHAMT_W-1:0] count_nxt;

    // Single-position shift; reserved op code falls through to SLL.
    function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] v,
                                               input logic [1:0]       o);
        logic signed [WIDTH-1:0] sv;
        sv = $signed(v);
        case (o)
            OP_SRL:  step1 = v >> 1;
            OP_SRA:  step1 = WIDTH'(sv >>> 1);
            default: step1 = v << 1;
        endcase
    endfunction

`ifdef SHIFT_SEQ_FAST4_EN
    // Four-position shift with the same fill rules as step1.
    function automatic logic [WIDTH-1:0] step4(input logic [WIDTH-1:0] v,
                                               input logic [1:0]       o);
        logic signed [WIDTH-1:0] sv;
        sv = $signed(v);
        case (o)
            OP_SRL:  step4 = v >> 4;
            OP_SRA:  step4 = WIDTH'(sv >>> 4);
            default: step4 = v << 4;
        endcase
    endfunction
`endif

    always_comb begin
        shifted   = step1(work, op_r);
        count_nxt = count - CNT_ONE;
`ifdef SHIFT_SEQ_FAST4_EN
        if (count >= CNT_FOUR) begin
            shifted   = step4(work, op_r);
            count_nxt = count - CNT_FOUR;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            work   <= '0;
            count  <= '0;
            op_r   <= 2'b00;
        end else begin
            case (state)
                // DONE accepts a new request too, giving back-to-back issue.
                IDLE, DONE: begin
                    if (start) begin
                        work  <= data_in;
                        op_r  <= op;
                        count <= shamt;
                        if (shamt == '0) begin
                            // Nothing to shift: complete straight away.
                            result <= data_in;
                            state  <= DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            state <= SHIFT;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end

                // start is ignored here; inputs are never re-sampled.
                SHIFT: begin
                    work  <= shifted;
                    count <= count_nxt;
                    // The step that consumes the last position publishes the
                    // value; intermediate values never reach result.
                    if (count_nxt == '0) begin
                        result <= shifted;
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] data_in = '0;
    logic [4:0]  shamt = '0;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_result = '0;

    shift_seq_ctrl #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .data_in (data_in),
        .shamt   (shamt),
        .result  (result),
        .busy    (busy),
        .done    (done)
    );

    always #5 clock = ~clock;

    // Reference: what the shift should produce, straight from the op definition.
    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d,
                                              input int n);
        logic signed [31:0] sd;
        sd = $signed(d);
        case (o)
            2'b01:   return d >> n;
            2'b10:   return sd >>> n;
            default: return d << n;
        endcase
    endfunction

    function automatic int ref_latency(input int n);
`ifdef SHIFT_SEQ_FAST4_EN
        return n / 4 + n % 4;
`else
        return n;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request at the current (negedge) time and follow it to done.
    // Returns at the negedge where done is high, so calling again immediately
    // issues a back-to-back request from DONE. If inject is set, a second
    // start with different data is held across the first SHIFT edge.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] d,
                          input logic [4:0] n, input bit inject);
        int lat;
        logic [31:0] exp_new;
        lat     = ref_latency(int'(n));
        exp_new = ref_shift(o, d, int'(n));
        start = 1'b1; op = o; data_in = d; shamt = n;
        @(posedge clock);                       // E0
        @(negedge clock);
        start = 1'b0;
        if (inject && lat >= 2) begin
            start = 1'b1; op = 2'b01; data_in = 32'h1234_5678; shamt = 5'd3;
        end
        for (int c = 0; c < lat; c++) begin
            check({tag, " busy"}, {31'b0, busy}, 32'd1);
            check({tag, " done_low"}, {31'b0, done}, 32'd0);
            check({tag, " result_held"}, result, exp_result);
            @(negedge clock);
            start = 1'b0;
        end
        exp_result = exp_new;
        check({tag, " done"}, {31'b0, done}, 32'd1);
        check({tag, " busy_low"}, {31'b0, busy}, 32'd0);
        check({tag, " result"}, result, exp_result);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clock);
        check({tag, " idle_busy"}, {31'b0, busy}, 32'd0);
        check({tag, " idle_done"}, {31'b0, done}, 32'd0);
        check({tag, " idle_result"}, result, exp_result);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst result", result, 32'h0);
        check("rst busy", {31'b0, busy}, 32'd0);
        check("rst done", {31'b0, done}, 32'd0);
        reset = 1'b0;
        idle_check("post_rst");

        // Directed cases
        run_op("sll1x4", 2'b00, 32'h0000_0001, 5'd4, 1'b0);
        check("sll1x4 val", result, 32'h0000_0010);
        idle_check("a");
        run_op("sra31", 2'b10, 32'h8000_0000, 5'd31, 1'b0);
        check("sra31 val", result, 32'hFFFF_FFFF);
        idle_check("b");
        run_op("srl31", 2'b01, 32'h8000_0000, 5'd31, 1'b0);
        check("srl31 val", result, 32'h0000_0001);
        idle_check("c");
        run_op("sra0", 2'b10, 32'hDEAD_BEEF, 5'd0, 1'b0);
        check("sra0 val", result, 32'hDEAD_BEEF);
        idle_check("d");
        run_op("ignore", 2'b00, 32'h0000_000F, 5'd8, 1'b1);
        check("ignore val", result, 32'h0000_0F00);
        // Back-to-back from the DONE cycle
        run_op("b2b", 2'b10, 32'h8765_4321, 5'd5, 1'b0);
        check("b2b val", result, 32'hFC3B_2A19);
        idle_check("e");
        run_op("rsv_op", 2'b11, 32'h0000_0003, 5'd2, 1'b0);
        idle_check("f");

        // Reset mid-SHIFT: reset is sampled at E3
        start = 1'b1; op = 2'b01; data_in = 32'hF000_0000; shamt = 5'd16;
        @(posedge clock);
        @(negedge clock); start = 1'b0;
        check("mid busy1", {31'b0, busy}, 32'd1);
        @(negedge clock);
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        exp_result = '0;
        check("mid rst result", result, 32'h0);
        check("mid rst busy", {31'b0, busy}, 32'd0);
        check("mid rst done", {31'b0, done}, 32'd0);
        for (int i = 0; i < 20; i++) idle_check("mid quiet");
        run_op("srl16", 2'b01, 32'hF000_0000, 5'd16, 1'b0);
        check("srl16 val", result, 32'h0000_F000);
        idle_check("g");
        run_op("sll3x7", 2'b00, 32'h0000_0003, 5'd7, 1'b0);
        check("sll3x7 val", result, 32'h0000_0180);
        idle_check("h");

        // Randomized requests against the reference model
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  ro;
            logic [31:0] rd;
            logic [4:0]  rn;
            ro = 2'($urandom_range(0, 3));
            rd = $urandom;
            rn = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0) run_op("rnd_b2b", ro, rd, rn, 1'b0);
            else begin
                idle_check("rnd");
                run_op("rnd", ro, rd, rn, $urandom_range(0, 3) == 0);
            end
        end
        idle_check("end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
